// File: rtl/im2col_mem_arb.sv
// Shares one single-port data SRAM between NUM_REQ engines with round-robin
// arbitration and a per-grant burst cap; define ARB_FIXED_PRIO_EN for fixed priority.
module im2col_mem_arb #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_we,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx;
    logic               owner_req;
    logic               owner_we;
    logic               access;

    // Handshake: a transfer happens in every cycle where gnt[k] & req[k]; the
    // requester keeps req and its addr/wdata/we stable until that cycle.
    assign owner_req = req[rr_ptr_q];
    assign owner_we  = req_we[rr_ptr_q];
    assign access    = (state_q == S_GRANT) && owner_req;

    // Loops run backwards so the last hit is the first in scan order.
    always_comb begin
        winner = '0;
        idx    = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'(i);
            if (req[idx]) winner = idx;
        end
`else
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req[idx]) winner = idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        rvalid_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d     = S_GRANT;
                    gnt_d       = NUM_REQ'(1) << winner;
                    rr_ptr_d    = winner;
                    burst_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        // Read data returns one cycle later, even if the grant has been released.
        if (access && !owner_we) rvalid_d = NUM_REQ'(1) << rr_ptr_q;
    end

    always_comb begin
        gnt       = gnt_q;
        rvalid    = rvalid_q;
        rdata     = mem_rdata;
        busy      = (state_q == S_GRANT);
        mem_en    = access;
        mem_we    = access && owner_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (access) begin
            mem_addr  = req_addr[rr_ptr_q*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = req_wdata[rr_ptr_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_im2col_mem_arb.sv
// Scoreboard bench for im2col_mem_arb: per-requester drivers, an SRAM model,
// and a monitor checking every memory access and read return against queues.
module tb_im2col_mem_arb;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int MB = 16;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_we;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             busy;

    im2col_mem_arb #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct {
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          gap;
    } acc_t;

    typedef struct {
        logic [2:0] vec;
        logic [7:0] data;
    } rv_t;

    txn_t drv_q [NR][$];
    txn_t plan_q[NR][$];
    acc_t exp_acc_q[$];
    rv_t  exp_rv_q[$];
    int   rd_cyc_q[$];
    logic [7:0] shadow[int];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [7:0] init_val(input logic [11:0] i);
        return i[7:0] ^ 8'(i[11:8]) ^ 8'h3C;
    endfunction

    // SRAM model, 4K entries aliased on the low address bits
    logic [7:0] memv[0:4095];
    bit         written[0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                memv[mem_addr[11:0]]    <= mem_wdata;
                written[mem_addr[11:0]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[11:0]] ? memv[mem_addr[11:0]]
                                                     : init_val(mem_addr[11:0]);
            end
        end
    end

    task automatic chk(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic sched(input int r, input logic we, input logic [31:0] addr,
                         input logic [7:0] wdata);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = wdata;
        drv_q[r].push_back(t);
        plan_q[r].push_back(t);
    endtask

    // Move the next n planned transactions of requester r into the expected
    // access stream; first_gap is the cycle distance from the previous access.
    task automatic expect_from(input int r, input int n, input int first_gap);
        txn_t t;
        acc_t a;
        rv_t  v;
        int   ix;
        for (int k = 0; k < n; k++) begin
            t = plan_q[r].pop_front();
            a.r = r;
            a.we = t.we;
            a.addr = t.addr;
            a.wdata = t.wdata;
            a.gap = (k == 0) ? first_gap : 1;
            exp_acc_q.push_back(a);
            ix = int'(t.addr[11:0]);
            if (t.we) begin
                shadow[ix] = t.wdata;
            end else begin
                v.vec = 3'(1 << r);
                v.data = shadow.exists(ix) ? shadow[ix] : init_val(t.addr[11:0]);
                exp_rv_q.push_back(v);
            end
        end
    endtask

    task automatic drive_fields();
        for (int r = 0; r < NR; r++) begin
            if (drv_q[r].size() > 0) begin
                req[r] = 1'b1;
                req_we[r] = drv_q[r][0].we;
                req_addr[r*AW +: AW] = drv_q[r][0].addr;
                req_wdata[r*DW +: DW] = drv_q[r][0].wdata;
            end else begin
                req[r] = 1'b0;
                req_we[r] = 1'b1;
                req_addr[r*AW +: AW] = 32'hFFFF_0000 + 32'(r);
                req_wdata[r*DW +: DW] = 8'(32'hE0 + r);
            end
        end
    endtask

    initial begin
        logic [NR-1:0] acc_s;
        drive_fields();
        forever begin
            @(negedge clk);
            acc_s = req & gnt;
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++)
                if (acc_s[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
            drive_fields();
        end
    end

    // monitor / scoreboard
    initial begin
        acc_t        e;
        rv_t         v;
        int          gap;
        int          rc;
        logic [63:0] act;
        logic [63:0] ex;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_en) begin
                    if (exp_acc_q.size() == 0) begin
                        chk("unexpected_access", 1'b0, 64'({gnt, mem_we, mem_addr, mem_wdata}), 64'd0);
                    end else begin
                        e = exp_acc_q.pop_front();
                        gap = (e.gap == 0) ? 0 : cyc - last_acc_cyc;
                        act = 64'({gnt, mem_we, mem_addr, mem_wdata, 8'(gap)});
                        ex  = 64'({3'(1 << e.r), e.we, e.addr, e.wdata, 8'(e.gap)});
                        chk("access", act == ex, act, ex);
                    end
                    last_acc_cyc = cyc;
                    if (!mem_we) rd_cyc_q.push_back(cyc);
                end else begin
                    chk("idle_outputs", !mem_we && mem_addr == '0 && mem_wdata == '0,
                        64'({mem_we, mem_addr, mem_wdata}), 64'd0);
                end
                if (rvalid != '0) begin
                    if (exp_rv_q.size() == 0) begin
                        chk("unexpected_rvalid", 1'b0, 64'({rvalid, rdata}), 64'd0);
                    end else begin
                        v = exp_rv_q.pop_front();
                        rc = (rd_cyc_q.size() > 0) ? rd_cyc_q.pop_front() : -100;
                        act = 64'({rvalid, rdata, 8'(cyc - rc)});
                        ex  = 64'({v.vec, v.data, 8'd1});
                        chk("read_return", act == ex, act, ex);
                    end
                end
            end
        end
    end

    function automatic bit all_empty();
        bit e;
        e = (exp_acc_q.size() == 0) && (exp_rv_q.size() == 0);
        for (int r = 0; r < NR; r++) if (drv_q[r].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic flush_all();
        for (int r = 0; r < NR; r++) begin
            drv_q[r].delete();
            plan_q[r].delete();
        end
        exp_acc_q.delete();
        exp_rv_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (k < 400 && !all_empty()) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk({name, "_drain"}, all_empty(), 64'(exp_acc_q.size() + exp_rv_q.size()), 64'd0);
        flush_all();
        repeat (3) @(negedge clk);
        #2;
        chk({name, "_idle_after"}, gnt == '0 && !busy, 64'({gnt, busy}), 64'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        #12;
        chk("reset_outputs",
            gnt == '0 && rvalid == '0 && !mem_en && !mem_we && mem_addr == '0 &&
            mem_wdata == '0 && !busy,
            64'({gnt, rvalid, mem_en, mem_we, busy, mem_addr[15:0], mem_wdata}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: sole requester 1, four reads; grant one cycle after req rises
        for (int i = 0; i < 4; i++) sched(1, 1'b0, 32'h2000 + 32'(i), 8'h11 + 8'(i));
        expect_from(1, 4, 0);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("t1_gnt_before", gnt == '0 && !busy, 64'({gnt, busy}), 64'd0);
        @(negedge clk);
        chk("t1_gnt_latency", gnt == 3'b010 && busy && mem_en,
            64'({gnt, busy, mem_en}), 64'({3'b010, 1'b1, 1'b1}));
        wait_drain("t1");

        // T2: all three busy; rr_ptr=1 after T1, so order is 2,0,1,0
        for (int i = 0; i < 20; i++) sched(0, 1'b0, 32'h1000 + 32'(i), 8'(i));
        for (int i = 0; i < 16; i++) sched(1, 1'(i), 32'h1100 + 32'(i), 8'h40 + 8'(i));
        for (int i = 0; i < 16; i++) sched(2, 1'b0, 32'h1200 + 32'(i), 8'h80 + 8'(i));
        expect_from(2, 16, 0);
        expect_from(0, 16, 2);
        expect_from(1, 16, 2);
        expect_from(0, 4, 2);
        wait_drain("t2");

        // T3: sole requester 2 for 19 reads: 16, bubble, regrant, 3
        for (int i = 0; i < 19; i++) sched(2, 1'b0, 32'h3000 + 32'(i), 8'hC0 + 8'(i));
        expect_from(2, 16, 0);
        expect_from(2, 3, 2);
        wait_drain("t3");

        // T4: write 0xA5 to 0x0010 then read it back
        sched(1, 1'b1, 32'h0000_0010, 8'hA5);
        sched(1, 1'b0, 32'h0000_0010, 8'h00);
        expect_from(1, 2, 0);
        wait_drain("t4");

        // T5: asynchronous reset after the fifth access of requester 0
        for (int i = 0; i < 10; i++) sched(0, 1'b0, 32'h4000 + 32'(i), 8'h20 + 8'(i));
        expect_from(0, 5, 0);
        k = 0;
        while (k < 100 && exp_acc_q.size() != 0) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("t5_reach_fifth", exp_acc_q.size() == 0, 64'(exp_acc_q.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", gnt == '0 && !mem_en && rvalid == '0 && !busy,
            64'({gnt, mem_en, rvalid, busy}), 64'd0);
        flush_all();
        repeat (2) @(negedge clk);
        chk("t5_held_in_reset", gnt == '0 && rvalid == '0 && !mem_en,
            64'({gnt, rvalid, mem_en}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) sched(1, 1'b0, 32'h5000 + 32'(i), 8'h50 + 8'(i));
        for (int i = 0; i < 3; i++) sched(0, 1'b0, 32'h5100 + 32'(i), 8'h60 + 8'(i));
        expect_from(0, 3, 0);
        expect_from(1, 3, 3);
        wait_drain("t5");

        // T6: requesters 0 and 2 together; rr_ptr=1 here
        for (int i = 0; i < 20; i++) sched(0, 1'b0, 32'h6000 + 32'(i), 8'h70 + 8'(i));
        for (int i = 0; i < 3; i++) sched(2, 1'b0, 32'h6100 + 32'(i), 8'h90 + 8'(i));
`ifdef ARB_FIXED_PRIO_EN
        expect_from(0, 16, 0);
        expect_from(0, 4, 2);
        expect_from(2, 3, 3);
`else
        expect_from(2, 3, 0);
        expect_from(0, 16, 3);
        expect_from(0, 4, 2);
`endif
        wait_drain("t6");

        chk("final_queues_empty", all_empty() && rd_cyc_q.size() == 0,
            64'(rd_cyc_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
